rd_ptr_fwft_gen: RTL and testbench

RD_PTR_FWFT_GEN -- requirements
Module: rd_ptr_fwft_gen

---
 rtl/rd_ptr_fwft_pkg.sv | 29 ++
 rtl/rd_ptr_fwft_gen_gray_to_bin.sv | 15 +
 rtl/rd_ptr_fwft_gen.sv | 122 ++++++++++++
 tb/tb_rd_ptr_fwft_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rd_ptr_fwft_pkg.sv
// Shared definitions for the first-word-fall-through read-pointer block:
// FSM state encoding and Gray/binary conversion helpers.
// The helpers work on a 32-bit container; callers zero-extend narrower
// pointers in and truncate the result back to their own width.
package rd_ptr_fwft_pkg;

    typedef logic [1:0] fwft_state_t;

    // IDLE: no word held and no read in flight
    // FETCH: a RAM read was issued last cycle, data arrives this cycle
    // VALID: rd_data holds a word that has not been accepted yet
    localparam fwft_state_t IDLE  = 2'd0;
    localparam fwft_state_t FETCH = 2'd1;
    localparam fwft_state_t VALID = 2'd2;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/rd_ptr_fwft_gen_gray_to_bin.sv
// Width-parameterised Gray-to-binary converter, used to turn the
// synchronised write pointer into a binary count for the level math.
module gray_to_bin
    import rd_ptr_fwft_pkg::*;
#(
    parameter int WIDTH = 5
)(
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Purely combinational: zero-extend, convert, truncate back.
    assign bin = WIDTH'(gray2bin(32'(gray)));

endmodule

// File: rtl/rd_ptr_fwft_gen.sv
// Read side of an async FIFO with first-word-fall-through output.
// Keeps the binary/Gray read pointer, fetches words from a RAM with
// one cycle of read latency, and presents them on rd_data/rd_valid.
// Optional feature: define RD_PTR_FWFT_AE_EN to add the AE_THRESH
// parameter and the registered rd_almost_empty output.
module rd_ptr_fwft_gen
    import rd_ptr_fwft_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int DATA_SIZE = 8
`ifdef RD_PTR_FWFT_AE_EN
    ,
    parameter int AE_THRESH = 2
`endif
)(
    input  logic                 rd_clk,
    input  logic                 rd_rst_n,
    input  logic [ADDR_SIZE:0]   sync_wrt_ptr,
    input  logic                 rd_ready,
    input  logic [DATA_SIZE-1:0] rd_mem_data,
    output logic                 rd_mem_en,
    output logic [ADDR_SIZE-1:0] rd_addr,
    output logic [ADDR_SIZE:0]   rd_ptr,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 rd_empty,
    output logic [ADDR_SIZE:0]   rd_level
`ifdef RD_PTR_FWFT_AE_EN
    ,
    output logic                 rd_almost_empty
`endif
);

    localparam int PW = ADDR_SIZE + 1;

    fwft_state_t       state;
    logic [ADDR_SIZE:0] rd_bin;
    logic [ADDR_SIZE:0] rd_bin_nxt;
    logic [ADDR_SIZE:0] wr_bin;

    gray_to_bin #(.WIDTH(PW)) u_wr_g2b (
        .gray (sync_wrt_ptr),
        .bin  (wr_bin)
    );

    assign rd_empty   = (sync_wrt_ptr == rd_ptr);
    assign rd_level   = wr_bin - rd_bin;
    assign rd_addr    = rd_bin[ADDR_SIZE-1:0];
    assign rd_bin_nxt = rd_bin + PW'(rd_mem_en);

    // Issue a RAM read only when a word is available and the output
    // register is free or being emptied this cycle; never in reset.
    always_comb begin
        rd_mem_en = 1'b0;
        if (rd_rst_n && !rd_empty) begin
            case (state)
                IDLE:    rd_mem_en = 1'b1;
                VALID:   rd_mem_en = rd_ready;
                default: rd_mem_en = 1'b0;
            endcase
        end
    end

    // Advance the binary read count per issued read; the Gray copy is
    // built from the next value so both registers stay in step.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rd_bin <= '0;
            rd_ptr <= '0;
        end else begin
            rd_bin <= rd_bin_nxt;
            rd_ptr <= PW'(bin2gray(32'(rd_bin_nxt)));
        end
    end

    // Output FSM: capture RAM data one cycle after the read, then hold
    // it until the consumer takes it.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_mem_en) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    rd_data  <= rd_mem_data;
                    rd_valid <= 1'b1;
                    state    <= VALID;
                end
                VALID: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        state    <= rd_mem_en ? FETCH : IDLE;
                    end
                end
                default: begin
                    rd_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef RD_PTR_FWFT_AE_EN
    localparam logic [ADDR_SIZE:0] AE_LIMIT = PW'(AE_THRESH);

    // Registered almost-empty flag; reads as set while in reset.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst_n) begin
            rd_almost_empty <= 1'b1;
        end else begin
            rd_almost_empty <= (rd_level <= AE_LIMIT);
        end
    end
`endif

endmodule

// File: tb/tb_rd_ptr_fwft_gen.sv
// Self-checking bench for rd_ptr_fwft_gen (ADDR_SIZE=4, DATA_SIZE=8).
// A transaction-level model (write count, fetch count, pending/held
// word) predicts every output each cycle; directed phases add literal
// expectations. rd_almost_empty is checked when RD_PTR_FWFT_AE_EN is set.
module tb_rd_ptr_fwft_gen;

    logic       rd_clk = 1'b0;
    logic       rd_rst_n;
    logic [4:0] sync_wrt_ptr;
    logic       rd_ready;
    logic [7:0] rd_mem_data = 8'h00;
    logic       rd_mem_en;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_empty;
    logic [4:0] rd_level;
`ifdef RD_PTR_FWFT_AE_EN
    logic       rd_almost_empty;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [16];

    // model state
    int         w_cnt = 0;
    int         f_cnt = 0;
    bit         m_pend = 1'b0;
    bit         m_valid = 1'b0;
    logic [7:0] m_pend_data = 8'h00;
    logic [7:0] m_data = 8'h00;
    bit         m_ae = 1'b1;
    bit         checking = 1'b0;
    int         accepted = 0;

    rd_ptr_fwft_gen #(.ADDR_SIZE(4), .DATA_SIZE(8)) dut (
        .rd_clk          (rd_clk),
        .rd_rst_n        (rd_rst_n),
        .sync_wrt_ptr    (sync_wrt_ptr),
        .rd_ready        (rd_ready),
        .rd_mem_data     (rd_mem_data),
        .rd_mem_en       (rd_mem_en),
        .rd_addr         (rd_addr),
        .rd_ptr          (rd_ptr),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_empty        (rd_empty),
        .rd_level        (rd_level)
`ifdef RD_PTR_FWFT_AE_EN
        ,
        .rd_almost_empty (rd_almost_empty)
`endif
    );

    always #5 rd_clk = ~rd_clk;

    function automatic logic [4:0] to_gray(input int n);
        logic [4:0] b;
        b = n[4:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_wr(input int n);
        w_cnt = n % 32;
        sync_wrt_ptr = to_gray(w_cnt);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    task automatic apply_stimulus(input int wr, input bit ready);
        rd_rst_n = 1'b0;
        set_wr(0);
        rd_ready = 1'b0;
        tick(1);
        rd_rst_n = 1'b1;
        set_wr(wr);
        rd_ready = ready;
    endtask

    // RAM with one cycle of read latency
    always @(posedge rd_clk) begin
        if (rd_mem_en) rd_mem_data <= mem[rd_addr];
    end

    // Transaction model: advances on each rising edge from pre-edge values
    always @(posedge rd_clk) begin
        int  lvl;
        bit  issue;
        lvl   = (w_cnt - f_cnt) & 31;
        issue = rd_rst_n && (lvl != 0) && !m_pend && (!m_valid || rd_ready);
        if (rd_rst_n && rd_valid && rd_ready) accepted++;
        if (!rd_rst_n) begin
            f_cnt = 0; m_pend = 1'b0; m_valid = 1'b0; m_data = 8'h00; m_ae = 1'b1;
        end else begin
            m_ae = (lvl <= 2);
            if (m_pend) begin
                m_valid = 1'b1;
                m_data  = m_pend_data;
                m_pend  = 1'b0;
            end else if (m_valid && rd_ready) begin
                m_valid = 1'b0;
            end
            if (issue) begin
                m_pend      = 1'b1;
                m_pend_data = mem[f_cnt % 16];
                f_cnt       = (f_cnt + 1) % 32;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge rd_clk) begin
        int lvl;
        bit issue;
        if (checking) begin
            lvl   = (w_cnt - f_cnt) & 31;
            issue = rd_rst_n && (lvl != 0) && !m_pend && (!m_valid || rd_ready);
            check_output("mdl_mem_en", rd_mem_en, issue);
            check_output("mdl_addr", rd_addr, f_cnt % 16);
            check_output("mdl_ptr", rd_ptr, to_gray(f_cnt));
            check_output("mdl_empty", rd_empty, lvl == 0);
            check_output("mdl_level", rd_level, lvl);
            check_output("mdl_valid", rd_valid, m_valid);
            check_output("mdl_data", rd_data, m_data);
`ifdef RD_PTR_FWFT_AE_EN
            check_output("mdl_ae", rd_almost_empty, m_ae);
`endif
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
        rd_ready = 1'b0;

        // Reset held with a non-empty write pointer
        rd_rst_n = 1'b0;
        set_wr(2);
        tick(1);
        checking = 1'b1;
        tick(1);
        @(negedge rd_clk);
        check_output("rst_ptr", rd_ptr, 5'b00000);
        check_output("rst_valid", rd_valid, 1'b0);
        check_output("rst_mem_en", rd_mem_en, 1'b0);
`ifdef RD_PTR_FWFT_AE_EN
        check_output("rst_ae", rd_almost_empty, 1'b1);
`endif
        @(posedge rd_clk); #1;
        rd_rst_n = 1'b1;
        @(negedge rd_clk);
        check_output("rel_mem_en", rd_mem_en, 1'b1);
        check_output("rel_addr", rd_addr, 4'd0);

        // Single word, consumer not ready
        apply_stimulus(1, 1'b0);
        @(negedge rd_clk);
        check_output("one_mem_en", rd_mem_en, 1'b1);
        check_output("one_addr", rd_addr, 4'd0);
        @(negedge rd_clk);
        check_output("one_ptr", rd_ptr, 5'b00001);
        check_output("one_valid_early", rd_valid, 1'b0);
        check_output("one_empty", rd_empty, 1'b1);
        @(negedge rd_clk);
        check_output("one_valid", rd_valid, 1'b1);
        check_output("one_data", rd_data, 8'h10);
        repeat (3) @(negedge rd_clk);
        check_output("one_hold_valid", rd_valid, 1'b1);
        check_output("one_hold_data", rd_data, 8'h10);
        check_output("one_hold_mem_en", rd_mem_en, 1'b0);

        // Four-word burst, consumer always ready
        apply_stimulus(4, 1'b1);
        accepted = 0;
        tick(12);
        @(negedge rd_clk);
        check_output("burst_accepted", accepted, 4);
        check_output("burst_ptr", rd_ptr, 5'b00110);
        check_output("burst_level", rd_level, 5'd0);
        check_output("burst_valid", rd_valid, 1'b0);

        // Pointer wrap from rd_bin=15
        apply_stimulus(15, 1'b1);
        tick(34);
        @(negedge rd_clk);
        check_output("wrap_ptr15", rd_ptr, 5'b01000);
        check_output("wrap_addr15", rd_addr, 4'd15);
        @(posedge rd_clk); #1;
        set_wr(17);
        @(negedge rd_clk);
        check_output("wrap_mem_en15", rd_mem_en, 1'b1);
        @(negedge rd_clk);
        check_output("wrap_ptr16", rd_ptr, 5'b11000);
        check_output("wrap_addr0", rd_addr, 4'd0);
        @(negedge rd_clk);
        check_output("wrap_data15", rd_data, 8'h1F);
        check_output("wrap_mem_en0", rd_mem_en, 1'b1);
        @(negedge rd_clk);
        check_output("wrap_ptr17", rd_ptr, 5'b11001);
        tick(4);

        // Level/almost-empty around the threshold
        apply_stimulus(3, 1'b0);
        @(negedge rd_clk);
        check_output("ae_level3", rd_level, 5'd3);
        @(negedge rd_clk);
        check_output("ae_level2", rd_level, 5'd2);
`ifdef RD_PTR_FWFT_AE_EN
        check_output("ae_clear", rd_almost_empty, 1'b0);
        @(negedge rd_clk);
        check_output("ae_set", rd_almost_empty, 1'b1);
`endif

        // Reset during FETCH discards the word
        apply_stimulus(2, 1'b0);
        @(posedge rd_clk); #1;
        rd_rst_n = 1'b0;
        @(negedge rd_clk);
        check_output("rstf_mem_en", rd_mem_en, 1'b0);
        check_output("rstf_valid0", rd_valid, 1'b0);
        @(negedge rd_clk);
        check_output("rstf_valid1", rd_valid, 1'b0);
        check_output("rstf_ptr", rd_ptr, 5'b00000);
        @(posedge rd_clk); #1;
        rd_rst_n = 1'b1;

        // Mixed traffic: writer trickles in, consumer stalls in a pattern
        begin
            logic [31:0] ready_pat;
            ready_pat = 32'b1011_0010_1110_0101_1100_1011_0111_0001;
            for (int i = 0; i < 60; i++) begin
                rd_ready = ready_pat[i % 32];
                if (i % 3 == 0) set_wr(w_cnt + 1);
                tick(1);
            end
        end
        rd_ready = 1'b1;
        tick(20);
        @(negedge rd_clk);
        check_output("drain_empty", rd_empty, 1'b1);
        check_output("drain_valid", rd_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
